// File: rtl/uart_pkg.sv
// Shared types and constants for the asynchronous-serial transmit and receive paths.
package uart_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int CLKS_PER_BIT_DEFAULT = 87;
    localparam int DATA_BITS_DEFAULT    = 8;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
endpackage

// File: rtl/uart_baud_gen.sv
// Reloadable bit-period down-counter; bit_done marks the last cycle of each bit period.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic en,
    output logic bit_done
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    assign bit_done = en && (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            cnt_q <= '0;
        else if (restart)      cnt_q <= RELOAD;
        else if (en) begin
            if (cnt_q == '0)   cnt_q <= RELOAD;
            else               cnt_q <= cnt_q - 1'b1;
        end
    end
endmodule

// File: rtl/uart_tx_serializer.sv
// Byte-to-serial transmitter: valid/ready in, registered glitch-free 8N1-style line out.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = DATA_BITS_DEFAULT,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);
    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic                   tx_q, tx_d;
    logic                   hs;
    logic                   bit_done;

    assign tx_ready = (state_q == IDLE);
    assign busy     = ~tx_ready;
    assign hs       = tx_valid & tx_ready;
    assign tx       = tx_q;

    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (hs),
        .en       (state_q != IDLE),
        .bit_done (bit_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= LINE_IDLE;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
        end
    end

    // tx_d is the level for the *next* bit period, so the pin flop changes
    // exactly on the bit boundary and never sees a decode glitch.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        case (state_q)
            IDLE: begin
                tx_d = LINE_IDLE;
                if (hs) begin
                    shreg_d   = tx_data;
                    bit_cnt_d = '0;
                    tx_d      = LINE_START;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_done) begin
                    tx_d    = shreg_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        tx_d      = LINE_IDLE;
                        state_d   = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = shreg_q[1];
                    end
                end
            end
            STOP: begin
                tx_d = LINE_IDLE;
                if (bit_done) begin
                    if (bit_cnt_q == LAST_STOP) state_d = IDLE;
                    else                        bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench: frames are captured per cycle and checked slot by slot against hand-built bit patterns.
module tb_uart_tx_serializer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       sel = 1'b0;

    logic tx1, rdy1, busy1, tx2, rdy2, busy2;
    logic tx_m, rdy_m, busy_m;

    always #5 clk = ~clk;

    uart_tx_serializer #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid & ~sel),
        .tx_ready(rdy1), .tx(tx1), .busy(busy1)
    );

    uart_tx_serializer #(.CLKS_PER_BIT(5), .DATA_BITS(7), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data[6:0]), .tx_valid(tx_valid & sel),
        .tx_ready(rdy2), .tx(tx2), .busy(busy2)
    );

    assign tx_m   = sel ? tx2   : tx1;
    assign rdy_m  = sel ? rdy2  : rdy1;
    assign busy_m = sel ? busy2 : busy1;

    int errors = 0, checks = 0;
    int cyc = 0, hs_cnt = 0, last_hs = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_valid && rdy_m) begin
            hs_cnt  <= hs_cnt + 1;
            last_hs <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    logic smp   [0:127];
    logic rdy_s [0:127];

    task automatic capture(input int n, input int set_at, input int clr_at, input logic [7:0] d);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            smp[k]   = tx_m;
            rdy_s[k] = rdy_m;
            if (k == set_at) begin
                tx_valid = 1'b1;
                tx_data  = d;
            end
            if (k == clr_at) tx_valid = 1'b0;
        end
    endtask

    // Returns #1 after the handshake edge, so the next negedge is sample 0 of the frame.
    task automatic handshake(input string tag, input logic [7:0] d, input bit hold);
        int t = 0;
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        while (!rdy_m && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_ready_wait"}, 32'(t < 200), 32'd1);
        chk({tag, "_pre_idle"}, 32'(tx_m), 32'd1);
        @(posedge clk);
        #1;
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [7:0] d, input int db,
                               input int sb, input int cpb, input int base);
        int nslot = 1 + db + sb;
        for (int s = 0; s < nslot; s++) begin
            logic [31:0] got, want;
            logic        lvl;
            got = '0;
            for (int c = 0; c < cpb; c++) got[c] = smp[base + s*cpb + c];
            if (s == 0)       lvl = 1'b0;
            else if (s <= db) lvl = d[s-1];
            else              lvl = 1'b1;
            want = lvl ? ((32'd1 << cpb) - 32'd1) : 32'd0;
            chk($sformatf("%s_slot%0d", tag, s), got, want);
        end
        chk({tag, "_busy_last"}, 32'(rdy_s[base + nslot*cpb - 1]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int h1, c0;
        logic [31:0] idle_bits;

        // Asynchronous reset: outputs settle between clock edges.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_tx",    32'(tx_m),   32'd1);
        chk("rst_ready", 32'(rdy_m),  32'd1);
        chk("rst_busy",  32'(busy_m), 32'd0);
        chk("rst_tx2",   32'(tx2 & rdy2 & ~busy2), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single 0xA5 frame.
        handshake("a5", 8'hA5, 1'b0);
        capture(42, -1, -1, 8'h00);
        check_frame("a5", 8'hA5, 8, 1, 4, 0);
        chk("a5_ready_back", 32'(rdy_s[40]), 32'd1);
        chk("a5_line_idle",  32'(smp[40]),   32'd1);

        // Back-to-back with tx_valid held: 0x00 then 0xFF.
        c0 = hs_cnt;
        handshake("b2b", 8'h00, 1'b1);
        h1 = last_hs;
        tx_data = 8'hFF;
        capture(84, -1, 41, 8'h00);
        chk("b2b_spacing", 32'(last_hs - h1), 32'd41);
        chk("b2b_hs_count", 32'(hs_cnt - c0), 32'd2);
        check_frame("b2b_a", 8'h00, 8, 1, 4, 0);
        chk("b2b_gap_high",  32'(smp[40]),   32'd1);
        chk("b2b_gap_ready", 32'(rdy_s[40]), 32'd1);
        check_frame("b2b_b", 8'hFF, 8, 1, 4, 41);
        chk("b2b_ready_back", 32'(rdy_s[81]), 32'd1);

        // tx_valid pulsed while busy is dropped.
        repeat (2) @(negedge clk);
        c0 = hs_cnt;
        handshake("busy", 8'hC3, 1'b0);
        capture(46, 10, 11, 8'h3C);
        check_frame("busy", 8'hC3, 8, 1, 4, 0);
        chk("busy_hs_count", 32'(hs_cnt - c0), 32'd1);
        idle_bits = '0;
        for (int k = 0; k < 6; k++) idle_bits[k] = smp[40 + k];
        chk("busy_idle_after", idle_bits, 32'h3F);

        // Reset during data bit 3 of 0x55, then a clean 0x81 frame.
        handshake("rst55", 8'h55, 1'b0);
        capture(17, -1, -1, 8'h00);
        chk("rst55_bit3_low", 32'(smp[16]), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst55_tx",    32'(tx_m),   32'd1);
        chk("rst55_ready", 32'(rdy_m),  32'd1);
        chk("rst55_busy",  32'(busy_m), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        capture(8, -1, -1, 8'h00);
        idle_bits = '0;
        for (int k = 0; k < 8; k++) idle_bits[k] = smp[k] & rdy_s[k];
        chk("rst55_no_resume", idle_bits, 32'hFF);
        handshake("r81", 8'h81, 1'b0);
        capture(42, -1, -1, 8'h00);
        check_frame("r81", 8'h81, 8, 1, 4, 0);
        chk("r81_ready_back", 32'(rdy_s[40]), 32'd1);

        // Parameter sweep instance: 5 clocks/bit, 7 data bits, 2 stop bits.
        @(negedge clk);
        sel = 1'b1;
        handshake("sw", 8'h7F, 1'b0);
        capture(52, -1, -1, 8'h00);
        check_frame("sw", 8'h7F, 7, 2, 5, 0);
        chk("sw_ready_back", 32'(rdy_s[50]), 32'd1);
        chk("sw_line_idle",  32'(smp[50]),   32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
